// File: rtl/can_bit_sampler_if.sv
// Signal bundle between the CAN bit sampler and its neighbours: raw line and
// enables in, destuffed bit strobe and status out.
interface can_bit_sampler_if;
    logic can_rx;
    logic sof;
    logic stuff_en;
    logic bit_valid;
    logic bit_data;
    logic stuff_err;
    logic active;

    modport master (
        output can_rx, sof, stuff_en,
        input  bit_valid, bit_data, stuff_err, active
    );

    modport slave (
        input  can_rx, sof, stuff_en,
        output bit_valid, bit_data, stuff_err, active
    );
endinterface

// File: rtl/can_bit_sampler.sv
// CAN bit sampler: hard sync on SOF, soft resync on recessive-to-dominant
// edges, programmable sample point, bit destuffing and stuff error detection.
module can_bit_sampler #(
    parameter int clk_speed_MHz    = 100,
    parameter int can_bit_rate_KHz = 1000,
    parameter int sample_pct       = 75,
    parameter int sjw_clks         = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    can_bit_sampler_if.slave bus
);

    localparam int CLKS_PER_BIT = clk_speed_MHz * 1000 / can_bit_rate_KHz;
    localparam int SAMPLE_PT    = CLKS_PER_BIT * sample_pct / 100;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);

    localparam logic [CNT_W-1:0] SAMPLE_C = CNT_W'(SAMPLE_PT);
    localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] SJW_C    = CNT_W'(sjw_clks);
    localparam logic [CNT_W-1:0] EARLY_C  = CNT_W'(CLKS_PER_BIT - sjw_clks);
    localparam logic [CNT_W:0]   SJW_P1_W = (CNT_W + 1)'(sjw_clks + 1);
    localparam logic [CNT_W:0]   CLKS_W   = (CNT_W + 1)'(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        ERROR
    } state_t;

    state_t state_q, state_d;

    logic             rx_meta, rx_s, rx_prev, rx_edge;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]       run_cnt_q, run_cnt_d;
    logic             run_val_q, run_val_d;
    logic             bit_valid_q, bit_valid_d;
    logic             bit_data_q, bit_data_d;
    logic             stuff_err_q, stuff_err_d;
    logic             active_q;

    logic [CNT_W-1:0] cnt_inc, cnt_late;
    logic [CNT_W:0]   late_sum;

    // Synchroniser idles recessive so leaving reset never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let each flop capture the value its
            // predecessor held before this edge, forming a true shift chain.
            rx_meta <= bus.can_rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign rx_edge = rx_prev & ~rx_s;

    assign cnt_inc  = (bit_cnt_q == LAST_C) ? '0 : bit_cnt_q + 1'b1;
    assign late_sum = {1'b0, bit_cnt_q} + SJW_P1_W;
    assign cnt_late = (late_sum >= CLKS_W) ? CNT_W'(late_sum - CLKS_W) : CNT_W'(late_sum);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        run_cnt_d   = run_cnt_q;
        run_val_d   = run_val_q;
        bit_valid_d = 1'b0;
        bit_data_d  = 1'b0;
        stuff_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                run_cnt_d = '0;
                run_val_d = 1'b1;
                if (bus.sof && !rx_s) begin
                    state_d   = ACTIVE;
                    bit_cnt_d = CNT_W'(1);
                end
            end

            ACTIVE: begin
                if (!bus.sof) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    run_cnt_d = '0;
                    run_val_d = 1'b1;
                end else begin
                    bit_cnt_d = cnt_inc;
                    if (bit_cnt_q == SAMPLE_C) begin
                        if (!bus.stuff_en) begin
                            bit_valid_d = 1'b1;
                            bit_data_d  = rx_s;
                            run_cnt_d   = '0;
                        end else if (run_cnt_q == 3'd5) begin
                            if (rx_s != run_val_q) begin
                                run_cnt_d = 3'd1;
                                run_val_d = rx_s;
                            end else begin
                                stuff_err_d = 1'b1;
                                state_d     = ERROR;
                            end
                        end else begin
                            bit_valid_d = 1'b1;
                            bit_data_d  = rx_s;
                            if (rx_s == run_val_q) begin
                                run_cnt_d = run_cnt_q + 3'd1;
                            end else begin
                                run_cnt_d = 3'd1;
                                run_val_d = rx_s;
                            end
                        end
                    end else if (rx_edge && bit_cnt_q != '0) begin
                        // Edge before the sample point stretches the bit; after it,
                        // the bit is shortened by at most sjw_clks.
                        if (bit_cnt_q <= SJW_C)         bit_cnt_d = CNT_W'(1);
                        else if (bit_cnt_q < SAMPLE_C)  bit_cnt_d = bit_cnt_q - SJW_C + 1'b1;
                        else if (bit_cnt_q >= EARLY_C)  bit_cnt_d = CNT_W'(1);
                        else                            bit_cnt_d = cnt_late;
                    end
                end
            end

            ERROR: begin
                if (!bus.sof) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    run_cnt_d = '0;
                    run_val_d = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q   <= '0;
            run_cnt_q   <= '0;
            run_val_q   <= 1'b1;
            bit_valid_q <= 1'b0;
            bit_data_q  <= 1'b0;
            stuff_err_q <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            run_cnt_q   <= run_cnt_d;
            run_val_q   <= run_val_d;
            bit_valid_q <= bit_valid_d;
            bit_data_q  <= bit_data_d;
            stuff_err_q <= stuff_err_d;
            active_q    <= (state_d == ACTIVE);
        end
    end

    assign bus.bit_valid = bit_valid_q;
    assign bus.bit_data  = bit_data_q;
    assign bus.stuff_err = stuff_err_q;
    assign bus.active    = active_q;

endmodule

// File: tb/tb_can_bit_sampler.sv
// Scoreboard bench for can_bit_sampler: stimulus queues expected strobes with
// their arrival cycle, a negedge monitor pops and compares each DUT event.
module tb_can_bit_sampler;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    can_bit_sampler_if bus();

    can_bit_sampler #(
        .clk_speed_MHz   (100),
        .can_bit_rate_KHz(1000),
        .sample_pct      (75),
        .sjw_clks        (10)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic is_err;
        logic data;
        int   cyc;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    // Monitor: every strobe or stuff error must match the head of the queue.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.bit_valid === 1'b1 || bus.stuff_err === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: bit_valid=%0b stuff_err=%0b at cycle %0d, want none",
                         bus.bit_valid, bus.stuff_err, cyc);
            end else begin
                e = exp_q.pop_front();
                check("event_cycle", cyc, e.cyc);
                check("event_kind", {31'd0, bus.stuff_err}, {31'd0, e.is_err});
                if (!e.is_err) check("bit_data", {31'd0, bus.bit_data}, {31'd0, e.data});
            end
        end
    end

    task automatic push_bit(input int c, input logic d);
        exp_t e;
        e.is_err = 1'b0;
        e.data   = d;
        e.cyc    = c;
        exp_q.push_back(e);
    endtask

    task automatic push_err(input int c);
        exp_t e;
        e.is_err = 1'b1;
        e.data   = 1'b0;
        e.cyc    = c;
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic start_frame(output int k0);
        @(negedge clk);
        k0          = cyc;
        bus.sof     = 1'b1;
        bus.can_rx  = 1'b0;
    endtask

    task automatic drive_rx(input int c, input logic v);
        wait_until(c);
        bus.can_rx = v;
    endtask

    task automatic end_frame(input int c);
        wait_until(c);
        bus.sof    = 1'b0;
        bus.can_rx = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k0;
        rst_n        = 1'b0;
        bus.can_rx   = 1'b1;
        bus.sof      = 1'b0;
        bus.stuff_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_bit_valid", {31'd0, bus.bit_valid}, 0);
        check("rst_bit_data",  {31'd0, bus.bit_data},  0);
        check("rst_stuff_err", {31'd0, bus.stuff_err}, 0);
        check("rst_active",    {31'd0, bus.active},    0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Bits 0,1,1,0: first strobe 78 cycles after the falling line.
        start_frame(k0);
        push_bit(k0 + 78, 0);
        push_bit(k0 + 178, 1);
        push_bit(k0 + 278, 1);
        push_bit(k0 + 378, 0);
        wait_until(k0 + 2);
        check("active_before_sync", {31'd0, bus.active}, 0);
        wait_until(k0 + 3);
        check("active_after_sync", {31'd0, bus.active}, 1);
        drive_rx(k0 + 100, 1);
        drive_rx(k0 + 300, 0);
        end_frame(k0 + 400);

        // Five dominant bits, a recessive stuff bit, then dominant.
        start_frame(k0);
        for (int i = 0; i < 5; i++) push_bit(k0 + 78 + 100 * i, 0);
        push_bit(k0 + 678, 0);
        drive_rx(k0 + 500, 1);
        drive_rx(k0 + 600, 0);
        end_frame(k0 + 700);

        // Six dominant bits with destuffing: stuff error at the sixth sample.
        start_frame(k0);
        for (int i = 0; i < 5; i++) push_bit(k0 + 78 + 100 * i, 0);
        push_err(k0 + 578);
        wait_until(k0 + 577);
        check("active_before_err", {31'd0, bus.active}, 1);
        wait_until(k0 + 578);
        check("active_at_err", {31'd0, bus.active}, 0);
        wait_until(k0 + 850);
        check("active_in_error", {31'd0, bus.active}, 0);
        end_frame(k0 + 900);

        // Same six dominant bits without destuffing: six strobes, no error.
        bus.stuff_en = 1'b0;
        start_frame(k0);
        for (int i = 0; i < 6; i++) push_bit(k0 + 78 + 100 * i, 0);
        end_frame(k0 + 600);
        bus.stuff_en = 1'b1;

        // Resync: late edge (cnt 30 -> 21), early edge (cnt 5 -> 1),
        // after-sample edge (cnt 85 -> 96) and near-end edge (cnt 95 -> 1).
        start_frame(k0);
        push_bit(k0 + 78, 0);
        push_bit(k0 + 178, 1);
        push_bit(k0 + 288, 0);
        push_bit(k0 + 388, 1);
        push_bit(k0 + 493, 0);
        push_bit(k0 + 583, 0);
        push_bit(k0 + 678, 0);
        drive_rx(k0 + 100, 1);
        drive_rx(k0 + 230, 0);
        drive_rx(k0 + 330, 1);
        drive_rx(k0 + 415, 0);
        drive_rx(k0 + 495, 1);
        drive_rx(k0 + 500, 0);
        drive_rx(k0 + 585, 1);
        drive_rx(k0 + 600, 0);
        end_frame(k0 + 700);

        // sof dropped mid-bit: frame abandons, no further strobes.
        start_frame(k0);
        push_bit(k0 + 78, 0);
        drive_rx(k0 + 100, 1);
        wait_until(k0 + 150);
        check("active_before_sof_drop", {31'd0, bus.active}, 1);
        bus.sof = 1'b0;
        wait_until(k0 + 151);
        check("active_after_sof_drop", {31'd0, bus.active}, 0);
        end_frame(k0 + 400);

        // Reset pulsed mid-frame with sof still high and the line recessive.
        start_frame(k0);
        push_bit(k0 + 78, 0);
        drive_rx(k0 + 100, 1);
        wait_until(k0 + 150);
        rst_n = 1'b0;
        #1;
        check("active_in_reset", {31'd0, bus.active}, 0);
        check("bit_valid_in_reset", {31'd0, bus.bit_valid}, 0);
        wait_until(k0 + 155);
        rst_n = 1'b1;
        end_frame(k0 + 400);

        // A fresh SOF after the reset syncs again with the same latency.
        start_frame(k0);
        push_bit(k0 + 78, 0);
        push_bit(k0 + 178, 1);
        drive_rx(k0 + 100, 1);
        end_frame(k0 + 200);

        repeat (50) @(negedge clk);
        check("pending_events", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
